// File: rtl/reg_rename_file_if.sv
// rtl/reg_rename_file_if.sv - decoder/ROB-side bundle for the rename register file
// Purpose: groups the global ready, source lookup ports, rename, commit and
//          flush signals of reg_rename_file into one bundle.
// Ports (signals):
//   rdy                            global ready, low freezes all state
//   rd_idx / rd_busy / rd_value / rd_tag   READ_PORTS packed lookup ports
//   rename_en / rename_idx / rename_tag    destination rename at issue
//   commit_en / commit_idx / commit_tag / commit_value  in-order ROB commit
//   flush                          mispredict recovery
// Modports: master = decoder/ROB side, slave = register file.
interface reg_rename_file_if #(
  parameter int DATA_W     = 32,
  parameter int REG_IDX_W  = 5,
  parameter int ROB_IDX_W  = 4,
  parameter int READ_PORTS = 2
);
  logic                            rdy;
  logic [READ_PORTS*REG_IDX_W-1:0] rd_idx;
  logic [READ_PORTS-1:0]           rd_busy;
  logic [READ_PORTS*DATA_W-1:0]    rd_value;
  logic [READ_PORTS*ROB_IDX_W-1:0] rd_tag;
  logic                            rename_en;
  logic [REG_IDX_W-1:0]            rename_idx;
  logic [ROB_IDX_W-1:0]            rename_tag;
  logic                            commit_en;
  logic [REG_IDX_W-1:0]            commit_idx;
  logic [ROB_IDX_W-1:0]            commit_tag;
  logic [DATA_W-1:0]               commit_value;
  logic                            flush;

  modport master (
    output rdy, rd_idx, rename_en, rename_idx, rename_tag,
           commit_en, commit_idx, commit_tag, commit_value, flush,
    input  rd_busy, rd_value, rd_tag
  );

  modport slave (
    input  rdy, rd_idx, rename_en, rename_idx, rename_tag,
           commit_en, commit_idx, commit_tag, commit_value, flush,
    output rd_busy, rd_value, rd_tag
  );
endinterface

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with rename-tag tracking
// Purpose: holds value/busy/tag per architectural register, serves
//          combinational source lookups with a same-cycle commit bypass,
//          renames destinations at issue, writes ROB commits in order and
//          clears all rename state on flush.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  reg_rename_file_if.slave (rdy, read ports, rename, commit, flush)
module reg_rename_file #(
  parameter int DATA_W     = 32,
  parameter int REG_NUM    = 32,
  parameter int REG_IDX_W  = 5,
  parameter int ROB_IDX_W  = 4,
  parameter int READ_PORTS = 2
) (
  input logic            clk,
  input logic            rst,
  reg_rename_file_if.slave bus
);

  logic [DATA_W-1:0]    value_q [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [ROB_IDX_W-1:0] tag_q   [REG_NUM];

  // Register 0 and indices past the end of the file read as zero and
  // swallow writes.
  function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
    return (idx != '0) && (int'(idx) < REG_NUM);
  endfunction

  // Source lookups. The bypass lets a commit arriving this cycle satisfy a
  // dependent source without waiting a cycle for the register write.
  always_comb begin
    logic [REG_IDX_W-1:0] idx;
    logic                 hit;
    bus.rd_busy  = '0;
    bus.rd_value = '0;
    bus.rd_tag   = '0;
    idx          = '0;
    hit          = 1'b0;
    for (int p = 0; p < READ_PORTS; p++) begin
      idx = bus.rd_idx[p*REG_IDX_W +: REG_IDX_W];
      hit = 1'b0;
      if (idx_ok(idx)) begin
        hit = bus.commit_en && (bus.commit_idx == idx) &&
              busy_q[idx] && (tag_q[idx] == bus.commit_tag);
        if (hit) begin
          bus.rd_value[p*DATA_W +: DATA_W] = bus.commit_value;
        end else begin
          bus.rd_value[p*DATA_W +: DATA_W] = value_q[idx];
          bus.rd_busy[p]                   = busy_q[idx];
          if (busy_q[idx]) begin
            bus.rd_tag[p*ROB_IDX_W +: ROB_IDX_W] = tag_q[idx];
          end
        end
      end
    end
  end

  // State update. Later assignments in each iteration take priority:
  // commit write/busy-clear, then flush, then rename.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        value_q[r] <= '0;
        busy_q[r]  <= 1'b0;
        tag_q[r]   <= '0;
      end
    end else if (bus.rdy) begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (bus.commit_en && (bus.commit_idx == REG_IDX_W'(r))) begin
          value_q[r] <= bus.commit_value;
          // A stale tag means a younger rename owns the register.
          if (busy_q[r] && (tag_q[r] == bus.commit_tag)) begin
            busy_q[r] <= 1'b0;
          end
        end
        if (bus.flush) begin
          busy_q[r] <= 1'b0;
        end else if (bus.rename_en && (bus.rename_idx == REG_IDX_W'(r))) begin
          busy_q[r] <= 1'b1;
          tag_q[r]  <= bus.rename_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - self-checking bench for reg_rename_file
module tb_reg_rename_file;
  localparam int DW   = 32;
  localparam int NREG = 24;
  localparam int IW   = 5;
  localparam int TW   = 4;
  localparam int RP   = 2;

  logic clk;
  logic rst;
  logic chk_en;
  int   n_cmp;
  int   n_bad;

  logic [DW-1:0] m_val  [32];
  logic          m_busy [32];
  logic [TW-1:0] m_tag  [32];

  reg_rename_file_if #(.DATA_W(DW), .REG_IDX_W(IW), .ROB_IDX_W(TW), .READ_PORTS(RP)) bus ();

  reg_rename_file #(
    .DATA_W(DW), .REG_NUM(NREG), .REG_IDX_W(IW), .ROB_IDX_W(TW), .READ_PORTS(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_rng(input logic [IW-1:0] idx);
    return (idx != 0) && (int'(idx) < NREG);
  endfunction

  function automatic void model_read(input logic [IW-1:0] idx, output logic b,
                                     output logic [DW-1:0] v, output logic [TW-1:0] t);
    b = 1'b0; v = '0; t = '0;
    if (!in_rng(idx)) return;
    if (bus.commit_en && bus.commit_idx == idx && m_busy[idx] && m_tag[idx] == bus.commit_tag) begin
      v = bus.commit_value;
      return;
    end
    b = m_busy[idx];
    v = m_val[idx];
    t = b ? m_tag[idx] : '0;
  endfunction

  // Reference state follows the architectural rules for each edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_val[r] <= '0; m_busy[r] <= 1'b0; m_tag[r] <= '0;
      end
    end else if (bus.rdy) begin
      if (bus.commit_en && in_rng(bus.commit_idx)) begin
        m_val[bus.commit_idx] <= bus.commit_value;
        if (m_busy[bus.commit_idx] && m_tag[bus.commit_idx] == bus.commit_tag)
          m_busy[bus.commit_idx] <= 1'b0;
      end
      if (bus.flush) begin
        for (int r = 0; r < 32; r++) m_busy[r] <= 1'b0;
      end else if (bus.rename_en && in_rng(bus.rename_idx)) begin
        m_busy[bus.rename_idx] <= 1'b1;
        m_tag[bus.rename_idx]  <= bus.rename_tag;
      end
    end
  end

  // Per-cycle compare of every read port against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < RP; p++) begin
        logic          eb;
        logic [DW-1:0] ev;
        logic [TW-1:0] et;
        model_read(bus.rd_idx[p*IW +: IW], eb, ev, et);
        n_cmp++;
        if (bus.rd_busy[p] !== eb || bus.rd_value[p*DW +: DW] !== ev || bus.rd_tag[p*TW +: TW] !== et) begin
          n_bad++;
          $display("FAIL model_port%0d idx=%0d: got busy=%0b value=%h tag=%0d, want busy=%0b value=%h tag=%0d",
                   p, bus.rd_idx[p*IW +: IW], bus.rd_busy[p], bus.rd_value[p*DW +: DW],
                   bus.rd_tag[p*TW +: TW], eb, ev, et);
        end
      end
    end
  end

  task automatic lit(input string nm, input int p, input logic eb,
                     input logic [DW-1:0] ev, input logic [TW-1:0] et);
    n_cmp++;
    if (bus.rd_busy[p] !== eb || bus.rd_value[p*DW +: DW] !== ev || bus.rd_tag[p*TW +: TW] !== et) begin
      n_bad++;
      $display("FAIL %s: got busy=%0b value=%h tag=%0d, want busy=%0b value=%h tag=%0d",
               nm, bus.rd_busy[p], bus.rd_value[p*DW +: DW], bus.rd_tag[p*TW +: TW], eb, ev, et);
    end
  endtask

  task automatic idle();
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.rename_en = 1'b0; bus.rename_idx = '0; bus.rename_tag = '0;
    bus.commit_en = 1'b0; bus.commit_idx = '0; bus.commit_tag = '0; bus.commit_value = '0;
  endtask

  task automatic rd(input int a, input int b);
    bus.rd_idx[0 +: IW]  = IW'(a);
    bus.rd_idx[IW +: IW] = IW'(b);
  endtask

  task automatic rename(input int i, input int t);
    bus.rename_en = 1'b1; bus.rename_idx = IW'(i); bus.rename_tag = TW'(t);
  endtask

  task automatic commit(input int i, input int t, input logic [DW-1:0] v);
    bus.commit_en = 1'b1; bus.commit_idx = IW'(i); bus.commit_tag = TW'(t); bus.commit_value = v;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    idle(); rst = 1'b1; rd(5, 5);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;

    @(negedge clk); lit("reset_x5_p0", 0, 0, 0, 0); lit("reset_x5_p1", 1, 0, 0, 0);
    commit(5, 3, 32'hDEADBEEF); step();
    @(negedge clk); lit("commit_x5", 0, 0, 32'hDEADBEEF, 0);

    rd(7, 7); rename(7, 4); step();
    @(negedge clk); lit("rename_x7", 0, 1, 0, 4);
    commit(7, 4, 32'h1234);
    @(negedge clk); lit("bypass_x7", 1, 0, 32'h1234, 0);
    step();
    @(negedge clk); lit("state_x7", 0, 0, 32'h1234, 0);

    rename(7, 4); step(); rename(7, 9); step(); commit(7, 4, 32'h11); step();
    @(negedge clk); lit("stale_commit_x7", 0, 1, 32'h11, 9);

    rd(3, 3); commit(3, 2, 32'h55); rename(3, 6); step();
    @(negedge clk); lit("commit_rename_x3", 0, 1, 32'h55, 6);

    rename(1, 1); step(); rename(2, 2); step(); rename(3, 3); step();
    rd(2, 4); bus.flush = 1'b1; commit(2, 2, 32'h77); rename(4, 5); step();
    @(negedge clk); lit("flush_x2", 0, 0, 32'h77, 0); lit("flush_rename_x4", 1, 0, 0, 0);
    rd(1, 3); step();
    @(negedge clk); lit("flush_x1", 0, 0, 0, 0); lit("flush_x3", 1, 0, 32'h55, 0);

    rd(6, 4); rename(6, 5); step();
    bus.rdy = 1'b0; commit(6, 5, 32'hAB); rename(4, 8);
    @(negedge clk); lit("rdy0_bypass_x6", 0, 0, 32'hAB, 0);
    step();
    @(negedge clk); lit("rdy0_hold_x6", 0, 1, 0, 5); lit("rdy0_hold_x4", 1, 0, 0, 0);

    rd(0, 25); rename(0, 7); commit(0, 0, 32'h5A); step();
    rename(25, 3); commit(25, 0, 32'h66); step();
    @(negedge clk); lit("x0_zero", 0, 0, 0, 0); lit("x25_out_of_range", 1, 0, 0, 0);

    for (int c = 0; c < 2000; c++) begin
      int ci;
      rst = ($urandom_range(0, 199) == 0);
      bus.rdy = ($urandom_range(0, 9) != 0);
      bus.flush = ($urandom_range(0, 24) == 0);
      bus.rename_en = $urandom_range(0, 1);
      bus.rename_idx = IW'($urandom_range(0, 31) % (($urandom_range(0, 3) == 0) ? 32 : 8));
      bus.rename_tag = TW'($urandom);
      bus.commit_en = $urandom_range(0, 1);
      ci = $urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7);
      bus.commit_idx = IW'(ci);
      bus.commit_tag = ($urandom_range(0, 3) != 0) ? m_tag[ci] : TW'($urandom);
      bus.commit_value = $urandom;
      bus.rd_idx[0 +: IW]  = ($urandom_range(0, 2) == 0) ? IW'(ci) : IW'($urandom_range(0, 31));
      bus.rd_idx[IW +: IW] = ($urandom_range(0, 3) == 0) ? bus.rd_idx[0 +: IW] : IW'($urandom_range(0, 9));
      @(posedge clk); #1;
    end
    rst = 1'b0; idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
